// File: rtl/seg_pkg.sv
// seg_pkg -- shared definitions for the seg_accum_scan codebase slice.
//   HEX_SEG   : 16-entry hex-to-segment table, active-low, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK : all segments off (active-low)
//   disp_state_t : display scanner states
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, // 0
        7'b1111001, // 1
        7'b0100100, // 2
        7'b0110000, // 3
        7'b0011001, // 4
        7'b0010010, // 5
        7'b0000010, // 6
        7'b1111000, // 7
        7'b0000000, // 8
        7'b0010000, // 9
        7'b0001000, // A
        7'b0000011, // b
        7'b1000110, // C
        7'b0100001, // d
        7'b0000110, // E
        7'b0001110  // F
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SCAN  = 1'b1
    } disp_state_t;

endpackage

// File: rtl/seg_hex_dec.sv
// seg_hex_dec -- combinational hex digit to 7-segment decoder.
//   hex   in  4  nibble to decode
//   seg_L out 7  active-low segments {g,f,e,d,c,b,a}
module seg_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_L
);

    always_comb begin
        seg_L = HEX_SEG[hex];
    end

endmodule

// File: rtl/seg_accum_scan.sv
// seg_accum_scan -- add/subtract accumulator with sticky carry/borrow flag and
// a multiplexed hex display scanner.
//   clk      in  1      sole clock (rising edge)
//   rst      in  1      synchronous active-high reset, highest priority
//   a        in  WIDTH  operand
//   op_valid in  1      single-cycle operation request
//   sub      in  1      0 = acc+a, 1 = acc-a
//   clr      in  1      synchronous clear of acc/ovf, beats op_valid
//   acc      out WIDTH  registered accumulator
//   ovf      out 1      sticky carry/borrow
//   seg_L    out 7      registered active-low segments {g,f,e,d,c,b,a}
//   an_L     out NDIG   registered active-low digit enables
// Build option: define SEG_BLANK_LEADING_EN to blank leading-zero digits
// (digit 0 is always shown).
module seg_accum_scan
    import seg_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NDIG     = WIDTH / 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             op_valid,
    input  logic             sub,
    input  logic             clr,
    output logic [WIDTH-1:0] acc,
    output logic             ovf,
    output logic [6:0]       seg_L,
    output logic [NDIG-1:0]  an_L
);

    localparam int PW    = $clog2(SCAN_DIV);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [PW-1:0]    PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIG - 1);

    // ------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;

    always_comb begin
        sum_ext  = {1'b0, acc} + {1'b0, a};
        // MSB of the extended difference is the unsigned borrow (a > acc)
        diff_ext = {1'b0, acc} - {1'b0, a};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (op_valid) begin
            if (sub) begin
                acc <= diff_ext[WIDTH-1:0];
                if (diff_ext[WIDTH]) ovf <= 1'b1;
            end else begin
                acc <= sum_ext[WIDTH-1:0];
                if (sum_ext[WIDTH]) ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic          wrap;

    always_comb begin
        wrap = (presc_q == PRESC_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else if (wrap) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Display FSM
    // ------------------------------------------------------------------
    disp_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             load;
    logic [3:0]       nib_sel;
    logic [6:0]       seg_dec;
    logic [6:0]       seg_d;
    logic [NDIG-1:0]  an_d;
    logic [WIDTH-1:0] acc_hi;

    // First wrap out of BLANK shows digit 0; later wraps step the index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (wrap) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            ST_SCAN: begin
                if (wrap) begin
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    load  = 1'b1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                idx_d   = '0;
            end
        endcase
    end

    // Decode the nibble of the index being loaded so seg_L and an_L
    // update on the same edge.
    always_comb begin
        acc_hi  = acc >> {idx_d, 2'b00};
        nib_sel = acc_hi[3:0];
        an_d    = '1;
        an_d[idx_d] = 1'b0;
    end

    seg_hex_dec u_hex_dec (
        .hex   (nib_sel),
        .seg_L (seg_dec)
    );

    always_comb begin
        seg_d = seg_dec;
`ifdef SEG_BLANK_LEADING_EN
        // Digit and every higher digit zero: leading zero, blank it.
        if ((idx_d != '0) && (acc_hi == '0)) begin
            seg_d = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLANK;
            idx_q   <= '0;
            an_L    <= '1;
            seg_L   <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load) begin
                an_L  <= an_d;
                seg_L <= seg_d;
            end
        end
    end

endmodule

// File: doc/seg_accum_scan.md
SEG_ACCUM_SCAN -- requirements
Module: seg_accum_scan

Interface
REQ-001 SHALL have parameter WIDTH, default 8; accumulator width in bits, a multiple of 4 and at least 4.
REQ-002 SHALL have parameter NDIG = WIDTH/4; number of hex digits displayed.
REQ-003 SHALL have parameter SCAN_DIV, default 50000; clk cycles per digit slot, at least 2.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 a  in  WIDTH  operand.
REQ-007 op_valid  in  1  single-cycle operation request.
REQ-008 sub  in  1  operation select, sampled with op_valid: 0 = acc+a, 1 = acc-a.
REQ-009 clr  in  1  synchronous clear of acc and ovf.
REQ-010 acc  out  WIDTH  registered accumulator value.
REQ-011 ovf  out  1  sticky carry/borrow flag.
REQ-012 seg_L  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-013 an_L  out  NDIG  active-low digit enables, one-hot-low while scanning.

Function
REQ-014 On op_valid with sub=0: acc SHALL become (acc+a) mod 2^WIDTH at the next edge; ovf SHALL be set if the WIDTH+1-bit sum has its MSB set.
REQ-015 On op_valid with sub=1: acc SHALL become (acc-a) mod 2^WIDTH; ovf SHALL be set if a > acc (unsigned borrow).
REQ-016 ovf SHALL hold once set until clr or rst; an operation without carry/borrow SHALL NOT clear it.
REQ-017 clr and op_valid in the same cycle: clr wins; acc=0, ovf=0, and the operation is discarded.
REQ-018 Latency: acc and ovf reflect an operation exactly 1 cycle after op_valid; back-to-back op_valid every cycle SHALL be accepted with no stall.
REQ-019 Prescaler: counts 0..SCAN_DIV-1 and wraps. At wrap, the digit index SHALL advance 0..NDIG-1 and wrap to 0.
REQ-020 an_L SHALL be registered: bit[idx]=0, all other bits 1. Digit 0 is the least significant nibble.
REQ-021 seg_L SHALL be registered: hex decode of acc[4*idx+3:4*idx], using the acc value present when idx is loaded, so that seg_L and an_L change in the same cycle.
REQ-022 Hex codes (seg_L, {g..a}):
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000,
  8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 Display states: BLANK (after reset) -> SCAN at the first prescaler wrap. SCAN stays in SCAN; only rst returns the display to BLANK.

Reset
REQ-024 rst SHALL force: acc=0, ovf=0, prescaler=0, idx=0, state BLANK, an_L=all ones, seg_L=1111111.
REQ-025 rst SHALL take priority over clr and op_valid. rst asserted mid-scan SHALL abort the scan immediately at that edge.

Configuration
REQ-026 Macro SEG_BLANK_LEADING_EN.
  - Defined: a digit idx>0 whose nibble and all higher nibbles are zero SHALL drive seg_L=1111111, with its an_L still active. Digit 0 is always shown.
  - Undefined: all digits show their hex value, including leading zeros.

Structure
REQ-027 Shared package seg_pkg SHALL hold the 16-entry hex-to-segment constant table and the BLANK segment constant (1111111).
REQ-028 Hex decode SHALL be sub-module seg_hex_dec (4-bit in, 7-bit seg_L out, combinational), instantiated once and fed by the idx-selected nibble.

Verification (WIDTH=8, SCAN_DIV=4)
REQ-029 rst, then op_valid a=0x3C sub=0, then a=0x05 sub=0 -> acc=0x3C, then 0x41; ovf=0.
REQ-030 acc=0xF0, op_valid a=0x20 sub=0 -> acc=0x10, ovf=1; then a=0x01 -> acc=0x11, ovf stays 1; then clr -> acc=0x00, ovf=0.
REQ-031 acc=0x02, op_valid a=0x03 sub=1 -> acc=0xFF, ovf=1; clr and op_valid in the same cycle -> acc=0x00, ovf=0.
REQ-032 acc=0xA7, free run -> an_L alternates 10/01 every 4 cycles; seg_L=1111000 ("7") with an_L=10, seg_L=0001000 ("A") with an_L=01.
REQ-033 acc=0x05 with SEG_BLANK_LEADING_EN defined -> digit 1 shows 1111111; without the macro, digit 1 shows 1000000.
REQ-034 rst asserted while an_L=01 -> next cycle an_L=11, seg_L=1111111, acc=0x00; first enable appears after 4 cycles.
